// File: rtl/aliens_io_pkg.sv
// Shared register map and control-bit layout for the 0x5F80-0x5F9F I/O window.
package aliens_io_pkg;

  localparam logic [4:0] IO_DSW3 = 5'h00;
  localparam logic [4:0] IO_IN1  = 5'h01;
  localparam logic [4:0] IO_IN2  = 5'h02;
  localparam logic [4:0] IO_DSW2 = 5'h03;
  localparam logic [4:0] IO_DSW1 = 5'h04;
  localparam logic [4:0] IO_CTRL = 5'h08;
  localparam logic [4:0] IO_SND  = 5'h0C;

  localparam int CTRL_COIN1 = 0;
  localparam int CTRL_COIN2 = 1;
  localparam int CTRL_WOCO  = 5;
  localparam int CTRL_RMRD  = 6;
  localparam int CTRL_INIT  = 7;

  // Write decode only looks at the 4-byte bank, so mirrors hit the same register.
  function automatic logic in_bank(input logic [4:0] a, input logic [4:0] base);
    return a[4:2] == base[4:2];
  endfunction

endpackage

// File: rtl/aliens_pulse_stretch.sv
// Rising edge on trig starts (or restarts) a pulse exactly LEN cycles long.
module aliens_pulse_stretch #(
  parameter int LEN = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  output logic pulse
);

  localparam int CW = (LEN > 2) ? $clog2(LEN) : 1;

  logic          trig_q;
  logic          rise;
  logic [CW-1:0] cnt;

  assign rise  = trig & ~trig_q;
  // The edge cycle itself is the first pulse cycle, so the counter covers LEN-1.
  assign pulse = rise | (cnt != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_q <= 1'b0;
      cnt    <= '0;
    end else begin
      trig_q <= trig;
      if (rise)
        cnt <= CW'(LEN - 1);
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/aliens_io_responder.sv
// Target-side I/O responder: input/DIP reads, watchdog kick, control register,
// sound latch with IRQ handshake, stretched coin counter drives.
module aliens_io_responder
  import aliens_io_pkg::*;
#(
  parameter int WDT_FRAMES = 8,
  parameter int WDT_PULSE  = 16,
  parameter int COIN_MIN   = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iocs_n,
  input  logic       rw,
  input  logic [4:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_oe,
  input  logic [7:0] dsw1,
  input  logic [7:0] dsw2,
  input  logic [7:0] dsw3,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic       vblank,
  input  logic       snd_iack,
  output logic [7:0] snd_data,
  output logic       snd_irq,
  output logic       coin1,
  output logic       coin2,
  output logic       woco,
  output logic       rmrd,
  output logic       init,
  output logic       wdt_rst
);

  localparam int WW = $clog2(WDT_FRAMES + 1);

  logic          iocs_q;
  logic          start;
  logic          rd_start;
  logic          wr_start;
  logic          kick;
  logic [7:0]    rd_data;
  logic          coin1_req;
  logic          coin2_req;
  logic          vb_s1;
  logic          vb_s2;
  logic          vb_rise;
  logic [WW-1:0] wdt_cnt;
  logic          wdt_fire;
  logic          wdt_rst_q;
  logic          wdt_done;

  // iocs_q resets to 0, so a select still low when reset releases is not a start.
  assign start    = ~iocs_n & iocs_q;
  assign rd_start = start & rw;
  assign wr_start = start & ~rw;
  assign kick     = rd_start & (addr == IO_CTRL);

  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    rd_data = 8'hFF;
    case (addr)
      IO_DSW3: rd_data = dsw3;
      IO_IN1:  rd_data = in1;
      IO_IN2:  rd_data = in2;
      IO_DSW2: rd_data = dsw2;
      IO_DSW1: rd_data = dsw1;
      default: rd_data = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iocs_q  <= 1'b0;
      dout    <= 8'hFF;
      dout_oe <= 1'b0;
    end else begin
      iocs_q <= iocs_n;
      if (start) begin
        dout    <= rd_start ? rd_data : 8'hFF;
        dout_oe <= rw;
      end else if (iocs_n) begin
        dout    <= 8'hFF;
        dout_oe <= 1'b0;
      end
    end
  end

  // Control bits 2-4 have no consumer anywhere, so only the live bits are kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coin1_req <= 1'b0;
      coin2_req <= 1'b0;
      woco      <= 1'b0;
      rmrd      <= 1'b0;
      init      <= 1'b0;
    end else if (wr_start && in_bank(addr, IO_CTRL)) begin
      coin1_req <= din[CTRL_COIN1];
      coin2_req <= din[CTRL_COIN2];
      woco      <= din[CTRL_WOCO];
      rmrd      <= din[CTRL_RMRD];
      init      <= din[CTRL_INIT];
    end
  end

  // A write in the same cycle as the acknowledge wins: the new command must be seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snd_data <= 8'h00;
      snd_irq  <= 1'b0;
    end else if (wr_start && in_bank(addr, IO_SND)) begin
      snd_data <= din;
      snd_irq  <= 1'b1;
    end else if (snd_iack) begin
      snd_irq <= 1'b0;
    end
  end

  logic coin1_hold;
  logic coin2_hold;

  aliens_pulse_stretch #(.LEN(COIN_MIN)) u_coin1 (
    .clk   (clk),
    .reset (reset),
    .trig  (coin1_req),
    .pulse (coin1_hold)
  );

  aliens_pulse_stretch #(.LEN(COIN_MIN)) u_coin2 (
    .clk   (clk),
    .reset (reset),
    .trig  (coin2_req),
    .pulse (coin2_hold)
  );

  assign coin1 = coin1_req | coin1_hold;
  assign coin2 = coin2_req | coin2_hold;

  assign vb_rise  = vb_s1 & ~vb_s2;
  assign wdt_fire = (wdt_cnt == WW'(WDT_FRAMES));
  assign wdt_done = wdt_rst_q & ~wdt_rst;

  // Counter holds at WDT_FRAMES through the reset pulse and clears once it ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vb_s1     <= 1'b0;
      vb_s2     <= 1'b0;
      wdt_cnt   <= '0;
      wdt_rst_q <= 1'b0;
    end else begin
      vb_s1     <= vblank;
      vb_s2     <= vb_s1;
      wdt_rst_q <= wdt_rst;
      if (kick || wdt_done)
        wdt_cnt <= '0;
      else if (vb_rise && !wdt_fire)
        wdt_cnt <= wdt_cnt + WW'(1);
    end
  end

  aliens_pulse_stretch #(.LEN(WDT_PULSE)) u_wdt (
    .clk   (clk),
    .reset (reset),
    .trig  (wdt_fire),
    .pulse (wdt_rst)
  );

endmodule

// File: tb/tb_aliens_io_responder.sv
// Scoreboard-driven bench for aliens_io_responder: reads, control/coin, sound, watchdog, reset.
module tb_aliens_io_responder;
  import aliens_io_pkg::*;

  localparam int WDT_FRAMES = 8;
  localparam int WDT_PULSE  = 16;
  localparam int COIN_MIN   = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic       iocs_n;
  logic       rw;
  logic [4:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_oe;
  logic [7:0] dsw1, dsw2, dsw3, in1, in2;
  logic       vblank;
  logic       snd_iack;
  logic [7:0] snd_data;
  logic       snd_irq;
  logic       coin1, coin2, woco, rmrd, init, wdt_rst;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wdt_hi_total = 0;

  logic [7:0] rd_q[$];
  logic [7:0] snd_q[$];

  aliens_io_responder #(
    .WDT_FRAMES (WDT_FRAMES),
    .WDT_PULSE  (WDT_PULSE),
    .COIN_MIN   (COIN_MIN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .iocs_n   (iocs_n),
    .rw       (rw),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .dout_oe  (dout_oe),
    .dsw1     (dsw1),
    .dsw2     (dsw2),
    .dsw3     (dsw3),
    .in1      (in1),
    .in2      (in2),
    .vblank   (vblank),
    .snd_iack (snd_iack),
    .snd_data (snd_data),
    .snd_irq  (snd_irq),
    .coin1    (coin1),
    .coin2    (coin2),
    .woco     (woco),
    .rmrd     (rmrd),
    .init     (init),
    .wdt_rst  (wdt_rst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wdt_rst === 1'b1) wdt_hi_total <= wdt_hi_total + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout reached without finishing");
    $fatal(1);
  end

  task automatic do_read(input logic [4:0] a, input logic [7:0] exp);
    logic [7:0] e;
    rd_q.push_back(exp);
    @(negedge clk);
    iocs_n = 1'b0; rw = 1'b1; addr = a;
    @(negedge clk);
    e = rd_q.pop_front();
    checks++;
    if (dout !== e) begin
      errors++;
      $display("FAIL read_data addr=%h got=%h exp=%h", a, dout, e);
    end
    checks++;
    if (dout_oe !== 1'b1) begin
      errors++;
      $display("FAIL read_oe addr=%h got=%b exp=1", a, dout_oe);
    end
    iocs_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dout_oe !== 1'b0) begin
      errors++;
      $display("FAIL read_oe_release addr=%h got=%b exp=0", a, dout_oe);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    if (a[4:2] == IO_SND[4:2]) snd_q.push_back(d);
    @(negedge clk);
    iocs_n = 1'b0; rw = 1'b0; addr = a; din = d;
    @(negedge clk);
    checks++;
    if (dout_oe !== 1'b0) begin
      errors++;
      $display("FAIL write_oe addr=%h got=%b exp=0", a, dout_oe);
    end
    iocs_n = 1'b1;
  endtask

  task automatic check_snd(input string name, input logic exp_irq);
    logic [7:0] e;
    e = snd_q.pop_front();
    checks++;
    if (snd_data !== e || snd_irq !== exp_irq) begin
      errors++;
      $display("FAIL %s got data=%h irq=%b exp data=%h irq=%b", name, snd_data, snd_irq, e, exp_irq);
    end
  endtask

  task automatic vblank_pulse();
    @(negedge clk); vblank = 1'b1;
    repeat (2) @(negedge clk);
    vblank = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [23:0] got;
    reset = 1'b1; iocs_n = 1'b1; rw = 1'b1; addr = '0; din = '0;
    vblank = 1'b0; snd_iack = 1'b0;
    dsw3 = 8'hA1; in1 = 8'hB2; in2 = 8'hC3; dsw2 = 8'hD4; dsw1 = 8'hE5;
    repeat (3) @(negedge clk);
    got = {dout, dout_oe, snd_data, snd_irq, coin1, coin2, woco, rmrd, init, wdt_rst};
    checks++;
    if (got !== {8'hFF, 1'b0, 8'h00, 7'b0}) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", got, {8'hFF, 1'b0, 8'h00, 7'b0});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reads();
    checks++;
    if (dout_oe !== 1'b0) begin
      errors++;
      $display("FAIL idle_oe got=%b exp=0", dout_oe);
    end
    do_read(IO_DSW3, 8'hA1);
    do_read(IO_IN1,  8'hB2);
    do_read(IO_IN2,  8'hC3);
    do_read(IO_DSW2, 8'hD4);
    do_read(IO_DSW1, 8'hE5);
    do_read(5'h10,   8'hFF);
    do_read(5'h05,   8'hFF);
    in1 = 8'h3C;
    do_read(IO_IN1,  8'h3C);
  endtask

  task automatic test_ctrl_coin();
    int t0, t1, guard;
    do_write(IO_CTRL, 8'hE3);
    checks++;
    if ({woco, rmrd, init, coin1, coin2} !== 5'b11111) begin
      errors++;
      $display("FAIL ctrl_set got=%b exp=11111", {woco, rmrd, init, coin1, coin2});
    end
    t0 = cyc;
    do_write(IO_CTRL, 8'h00);
    checks++;
    if ({woco, rmrd, init, coin1, coin2} !== 5'b00011) begin
      errors++;
      $display("FAIL ctrl_clear got=%b exp=00011", {woco, rmrd, init, coin1, coin2});
    end
    guard = 0;
    while (coin1 === 1'b1 && guard < COIN_MIN + 50) begin
      @(negedge clk);
      guard++;
    end
    t1 = cyc;
    checks++;
    if (t1 - t0 !== COIN_MIN) begin
      errors++;
      $display("FAIL coin1_width got=%0d exp=%0d", t1 - t0, COIN_MIN);
    end
    checks++;
    if (coin2 !== 1'b0) begin
      errors++;
      $display("FAIL coin2_fall got=%b exp=0", coin2);
    end
  endtask

  task automatic test_sound();
    do_write(IO_SND, 8'h5A);
    check_snd("snd_first", 1'b1);
    do_write(5'h0D, 8'h77);
    check_snd("snd_overwrite", 1'b1);
    @(negedge clk); snd_iack = 1'b1;
    @(negedge clk); snd_iack = 1'b0;
    checks++;
    if (snd_irq !== 1'b0) begin
      errors++;
      $display("FAIL snd_iack got=%b exp=0", snd_irq);
    end
    snd_q.push_back(8'h3C);
    @(negedge clk);
    iocs_n = 1'b0; rw = 1'b0; addr = IO_SND; din = 8'h3C; snd_iack = 1'b1;
    @(negedge clk);
    snd_iack = 1'b0;
    check_snd("snd_write_beats_iack", 1'b1);
    iocs_n = 1'b1;
    do_write(5'h14, 8'hAA);
    do_write(5'h04, 8'h55);
    checks++;
    if (snd_data !== 8'h3C || {woco, rmrd, init} !== 3'b000) begin
      errors++;
      $display("FAIL ignored_write got data=%h ctrl=%b exp data=3c ctrl=000", snd_data, {woco, rmrd, init});
    end
  endtask

  task automatic test_watchdog();
    int base, guard;
    do_read(IO_CTRL, 8'hFF);
    base = wdt_hi_total;
    repeat (WDT_FRAMES) vblank_pulse();
    guard = 0;
    while (wdt_rst !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++;
      $display("FAIL wdt_fire_timeout got=no_pulse exp=pulse");
    end
    repeat (WDT_PULSE + 10) @(negedge clk);
    checks++;
    if (wdt_hi_total - base !== WDT_PULSE) begin
      errors++;
      $display("FAIL wdt_pulse_width got=%0d exp=%0d", wdt_hi_total - base, WDT_PULSE);
    end

    base = wdt_hi_total;
    repeat (3) begin
      repeat (WDT_FRAMES - 1) vblank_pulse();
      do_read(IO_CTRL, 8'hFF);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (wdt_hi_total - base !== 0) begin
      errors++;
      $display("FAIL wdt_kicked got=%0d exp=0", wdt_hi_total - base);
    end

    base = wdt_hi_total;
    repeat (WDT_FRAMES - 1) vblank_pulse();
    rd_q.push_back(8'hFF);
    @(negedge clk); vblank = 1'b1;
    @(negedge clk); iocs_n = 1'b0; rw = 1'b1; addr = IO_CTRL;
    @(negedge clk);
    checks++;
    if (dout !== rd_q[0]) begin
      errors++;
      $display("FAIL kick_read got=%h exp=%h", dout, rd_q[0]);
    end
    void'(rd_q.pop_front());
    iocs_n = 1'b1; vblank = 1'b0;
    repeat (2) @(negedge clk);
    repeat (WDT_FRAMES - 1) vblank_pulse();
    repeat (10) @(negedge clk);
    checks++;
    if (wdt_hi_total - base !== 0) begin
      errors++;
      $display("FAIL kick_beats_vblank got=%0d exp=0", wdt_hi_total - base);
    end
    vblank_pulse();
    guard = 0;
    while (wdt_rst !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++;
      $display("FAIL wdt_after_coincident got=no_pulse exp=pulse");
    end
    repeat (WDT_PULSE + 10) @(negedge clk);
  endtask

  task automatic test_held_select();
    @(negedge clk); snd_iack = 1'b1;
    @(negedge clk); snd_iack = 1'b0;
    snd_q.push_back(8'h11);
    @(negedge clk);
    iocs_n = 1'b0; rw = 1'b0; addr = IO_SND; din = 8'h11;
    @(negedge clk);
    check_snd("held_first", 1'b1);
    snd_iack = 1'b1;
    @(negedge clk);
    snd_iack = 1'b0; din = 8'h22;
    repeat (17) @(negedge clk);
    checks++;
    if (snd_data !== 8'h11 || snd_irq !== 1'b0) begin
      errors++;
      $display("FAIL held_once got data=%h irq=%b exp data=11 irq=0", snd_data, snd_irq);
    end
    iocs_n = 1'b1;
    do_write(IO_SND, 8'h22);
    check_snd("held_second", 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [23:0] got;
    do_write(IO_CTRL, 8'hE3);
    do_write(IO_SND, 8'h44);
    check_snd("pre_reset_snd", 1'b1);
    @(negedge clk);
    iocs_n = 1'b0; rw = 1'b0; addr = IO_SND; din = 8'h99;
    reset = 1'b1;
    #1;
    got = {dout, dout_oe, snd_data, snd_irq, coin1, coin2, woco, rmrd, init, wdt_rst};
    checks++;
    if (got !== {8'hFF, 1'b0, 8'h00, 7'b0}) begin
      errors++;
      $display("FAIL reset_mid_outputs got=%h exp=%h", got, {8'hFF, 1'b0, 8'h00, 7'b0});
    end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (snd_data !== 8'h00 || snd_irq !== 1'b0 || {woco, rmrd, init, coin1, coin2} !== 5'b0) begin
      errors++;
      $display("FAIL reset_release_no_write got data=%h irq=%b ctrl=%b exp data=00 irq=0 ctrl=00000",
               snd_data, snd_irq, {woco, rmrd, init, coin1, coin2});
    end
    iocs_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reads();
    test_ctrl_coin();
    test_sound();
    test_watchdog();
    test_held_select();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
